// File: rtl/fpnew_fma_issue_arbiter.sv
// rtl/fpnew_fma_issue_arbiter.sv - round-robin issue arbiter sharing one FMA pipe between requesters
// Optional per-requester grant/stall counters under FPNEW_FMA_ARB_STATS_EN.
module fpnew_fma_issue_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned ResWidth    = 38,
  parameter int unsigned MaxInflight = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic                        unit_valid_o,
  input  logic                        unit_ready_i,
  output logic [DataWidth-1:0]        unit_data_o,
  input  logic                        unit_out_valid_i,
  output logic                        unit_out_ready_o,
  input  logic [ResWidth-1:0]         unit_result_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output logic [ResWidth-1:0]         rsp_data_o,
  input  logic                        flush_i,
  output logic                        flush_o,
  output logic                        busy_o
`ifdef FPNEW_FMA_ARB_STATS_EN
  ,
  output logic [NumReq*32-1:0]        grant_cnt_o,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int unsigned IdWidth  = $clog2(NumReq);
  localparam int unsigned PtrWidth = (MaxInflight > 1) ? $clog2(MaxInflight) : 1;
  localparam int unsigned CntWidth = $clog2(MaxInflight + 1);

  logic [IdWidth-1:0]  rr_q, rr_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic [IdWidth-1:0]  fifo_q [MaxInflight];
  logic [IdWidth-1:0]  fifo_d [MaxInflight];

  logic [IdWidth-1:0]  grant, cand, head_id;
  logic                grant_found, any_valid, can_issue, issue, pop, fifo_empty;
  int unsigned         scan;

  // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxInflight - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    scan        = 0;
    cand        = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      scan = 32'(rr_q) + i;
      if (scan >= NumReq) scan = scan - NumReq;
      cand = IdWidth'(scan);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign any_valid  = |req_valid_i;
  assign fifo_empty = (count_q == '0);
  assign can_issue  = (count_q < CntWidth'(MaxInflight)) & ~flush_i;
  // Gating with rst_ni keeps the issue side quiet while reset is held.
  assign unit_valid_o = any_valid & can_issue & rst_ni;
  assign unit_data_o  = req_data_i[grant*DataWidth +: DataWidth];
  assign issue        = unit_valid_o & unit_ready_i;
  assign head_id      = fifo_q[rd_ptr_q];
  assign rsp_data_o   = unit_result_i;
  assign flush_o      = flush_i;
  assign busy_o       = ~fifo_empty | any_valid;

  always_comb begin
    req_ready_o = '0;
    if (unit_valid_o) req_ready_o[grant] = unit_ready_i;
  end

  // An orphan result (empty FIFO) is accepted and dropped.
  always_comb begin
    rsp_valid_o      = '0;
    unit_out_ready_o = 1'b1;
    if (!fifo_empty) begin
      rsp_valid_o[head_id] = unit_out_valid_i;
      unit_out_ready_o     = rsp_ready_i[head_id];
    end
  end

  assign pop = ~fifo_empty & unit_out_valid_i & rsp_ready_i[head_id];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    if (issue) begin
      fifo_d[wr_ptr_q] = grant;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      rr_d             = (grant == IdWidth'(NumReq - 1)) ? '0 : grant + IdWidth'(1);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (issue && !pop)      count_d = count_q + CntWidth'(1);
    else if (!issue && pop) count_d = count_q - CntWidth'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(MaxInflight); i++) fifo_q[i] <= '0;
    end else begin
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(unit_out_valid_i && fifo_empty));

`ifdef FPNEW_FMA_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NumReq];
  logic [31:0] grant_cnt_d [NumReq];
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue && grant_cnt_q[grant] != '1) grant_cnt_d[grant] = grant_cnt_q[grant] + 32'd1;
    if (any_valid && !issue && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumReq); i++) grant_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_cnt_out
    assign grant_cnt_o[g*32 +: 32] = grant_cnt_q[g];
  end
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpnew_fma_issue_arbiter.sv
// tb/tb_fpnew_fma_issue_arbiter.sv - randomized scoreboard bench for fpnew_fma_issue_arbiter
module tb_fpnew_fma_issue_arbiter;
  localparam int N  = 2;
  localparam int MI = 4;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [1:0]   req_valid, req_ready_o;
  logic [63:0]  rdata [2];
  logic [127:0] req_data;
  logic         unit_valid_o, unit_ready;
  logic [63:0]  unit_data_o;
  logic         unit_out_valid, unit_out_ready_o;
  logic [37:0]  unit_result;
  logic [1:0]   rsp_valid_o, rsp_ready;
  logic [37:0]  rsp_data_o;
  logic         flush, flush_o, busy_o;
`ifdef FPNEW_FMA_ARB_STATS_EN
  logic [63:0]  grant_cnt_o;
  logic [31:0]  stall_cnt_o;
`endif

  assign req_data = {rdata[1], rdata[0]};

  always #5 clk = ~clk;

  fpnew_fma_issue_arbiter #(.NumReq(N), .DataWidth(64), .ResWidth(38), .MaxInflight(MI)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_data_i(req_data),
    .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready), .unit_data_o(unit_data_o),
    .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready_o), .unit_result_i(unit_result),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
    .flush_i(flush), .flush_o(flush_o), .busy_o(busy_o)
`ifdef FPNEW_FMA_ARB_STATS_EN
    , .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  typedef struct {
    int          owner;
    logic [63:0] data;
    int          cyc;
  } op_t;

  op_t         q[$];
  logic [37:0] exp_res [2][$];
  int          rr, cyc, checks, errors, n_issued;
  int          starve_cnt [2];
  int          m_g;
  bit          m_issue, m_pop, m_uv, ret_en, rnd_ret;

  function automatic logic [37:0] fma_res(input logic [63:0] d);
    return d[37:0] ^ {d[63:38], 12'hABC};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_reqs(input logic [1:0] want);
    for (int r = 0; r < N; r++) begin
      if (!want[r]) req_valid[r] = 1'b0;
      else if (!req_valid[r]) begin
        req_valid[r] = 1'b1;
        rdata[r]     = {$urandom, $urandom};
      end
    end
  endtask

  task automatic at_neg();
    int cnt, own;
    bit any, can, found;
    logic [1:0] exp_rq, exp_rv;
    bit exp_or;
    logic [37:0] e;
    @(negedge clk);
    cnt = q.size();
    any = |req_valid;
    can = (cnt < MI) && !flush;
    m_g = 0;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_valid[(rr + i) % N]) begin
        found = 1;
        m_g = (rr + i) % N;
      end
    end
    m_uv    = any && can;
    m_issue = m_uv && unit_ready;
    exp_rq  = m_issue ? (2'b01 << m_g) : 2'b00;
    chk("unit_valid_o", unit_valid_o, m_uv);
    chk("req_ready_o", req_ready_o, exp_rq);
    if (m_uv) chk("unit_data_o", unit_data_o, rdata[m_g]);
    own = 0;
    if (cnt > 0) begin
      own    = q[0].owner;
      exp_rv = unit_out_valid ? (2'b01 << own) : 2'b00;
      exp_or = rsp_ready[own];
    end else begin
      exp_rv = 2'b00;
      exp_or = 1'b1;
    end
    m_pop = (cnt > 0) && unit_out_valid && rsp_ready[own];
    chk("rsp_valid_o", rsp_valid_o, exp_rv);
    chk("unit_out_ready_o", unit_out_ready_o, exp_or);
    chk("busy_o", busy_o, (cnt != 0) || any);
    chk("flush_o", flush_o, flush);
    if (m_pop) begin
      e = exp_res[own].pop_front();
      chk("rsp_data_o", rsp_data_o, e);
    end
    if (m_issue) begin
      n_issued++;
      for (int r = 0; r < N; r++) begin
        if (r == m_g) starve_cnt[r] = 0;
        else if (req_valid[r]) begin
          starve_cnt[r]++;
          chk("starvation_bound", starve_cnt[r] <= N - 1, 1);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (flush) begin
      q.delete();
      for (int r = 0; r < N; r++) exp_res[r].delete();
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_issue) begin
        q.push_back('{m_g, rdata[m_g], cyc});
        exp_res[m_g].push_back(fma_res(rdata[m_g]));
        rr = (m_g + 1) % N;
        req_valid[m_g] = 1'b0;
      end
    end
  endtask

  task automatic step();
    if (ret_en && q.size() > 0 && (cyc - q[0].cyc) >= LAT && (!rnd_ret || $urandom_range(0, 3) != 0)) begin
      unit_out_valid = 1'b1;
      unit_result    = fma_res(q[0].data);
    end else begin
      unit_out_valid = 1'b0;
      unit_result    = 38'($urandom);
    end
    at_neg();
  endtask

  task automatic drain();
    int b;
    b = 0;
    new_reqs(2'b00);
    flush = 0; rsp_ready = 2'b11; ret_en = 1; rnd_ret = 0;
    while (q.size() > 0 && b < 100) begin
      step(); tick(); b++;
    end
    chk("drain_bound", q.size(), 0);
    step();
    chk("drain_idle_busy", busy_o, 0);
    tick();
  endtask

  initial begin
    int alt;
    logic [37:0] held;
    checks = 0; errors = 0; cyc = 0; rr = 0; n_issued = 0;
    starve_cnt[0] = 0; starve_cnt[1] = 0;
    rst_ni = 0; req_valid = 0; rdata[0] = 0; rdata[1] = 0;
    unit_ready = 0; unit_out_valid = 0; unit_result = 0; rsp_ready = 0; flush = 0;
    ret_en = 0; rnd_ret = 0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 2'b11; unit_ready = 1; #1;
    chk("rst_unit_valid", unit_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 2'b00);
    chk("rst_rsp_valid", rsp_valid_o, 2'b00);
    req_valid = 2'b00; unit_ready = 0;
    @(posedge clk); #1;
    rst_ni = 1;
    step();
    chk("idle_unit_valid", unit_valid_o, 0);
    chk("idle_busy", busy_o, 0);
    tick();

    // Only requester 1 while rr points at 0, then both.
    unit_ready = 1; rsp_ready = 2'b11; ret_en = 1;
    new_reqs(2'b10); step();
    chk("solo_r1_grant", req_ready_o, 2'b10);
    tick();
    new_reqs(2'b11); step();
    chk("rr_back_to_r0", req_ready_o, 2'b01);
    tick();
    alt = 1;
    for (int i = 0; i < 14; i++) begin
      new_reqs(2'b11); step();
      if (m_issue) begin
        chk("alternate_grant", req_ready_o, (alt == 1) ? 2'b10 : 2'b01);
        alt ^= 1;
      end
      tick();
    end
    drain();

    // Fill to MaxInflight with no results returned.
    ret_en = 0; n_issued = 0;
    for (int i = 0; i < 7; i++) begin
      new_reqs(2'b11); step(); tick();
    end
    chk("fill_issue_count", n_issued, 4);
    new_reqs(2'b11); step();
    chk("full_no_issue", unit_valid_o, 0);
    tick();
    ret_en = 1; step();
    chk("full_pop_no_issue", unit_valid_o, 0);
    chk("full_pop_rsp", rsp_valid_o != 2'b00, 1);
    tick();
    ret_en = 0; step();
    chk("issue_after_pop", unit_valid_o, 1);
    tick();
    drain();

    // Head owned by requester 1 with rsp_ready[1] held low.
    ret_en = 0;
    new_reqs(2'b10);
    held = fma_res(rdata[1]);
    step(); tick();
    new_reqs(2'b00);
    repeat (LAT) begin step(); tick(); end
    ret_en = 1; rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_out_ready", unit_out_ready_o, 0);
      chk("hold_rsp_valid", rsp_valid_o, 2'b10);
      chk("hold_rsp_data", rsp_data_o, held);
      tick();
    end
    drain();

    // Flush with two operations outstanding.
    ret_en = 0;
    for (int i = 0; i < 2; i++) begin
      new_reqs(2'b11); step(); tick();
    end
    flush = 1; new_reqs(2'b11); step();
    chk("flush_no_issue", unit_valid_o, 0);
    chk("flush_no_ready", req_ready_o, 2'b00);
    tick();
    flush = 0; new_reqs(2'b00); step();
    chk("flush_cleared_busy", busy_o, 0);
    chk("flush_empty_out_ready", unit_out_ready_o, 1);
    tick();

    // Randomized traffic.
    ret_en = 1; rnd_ret = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < N; r++)
        if (!req_valid[r] && $urandom_range(0, 2) != 0) begin
          req_valid[r] = 1'b1;
          rdata[r] = {$urandom, $urandom};
        end
      unit_ready = ($urandom_range(0, 3) != 0);
      rsp_ready  = 2'($urandom);
      flush      = ($urandom_range(0, 49) == 0);
      step(); tick();
    end
    unit_ready = 1;
    drain();

    // Asynchronous reset with three in flight.
    ret_en = 0;
    for (int i = 0; i < 3; i++) begin
      new_reqs(2'b11); step(); tick();
    end
    new_reqs(2'b11);
    #2;
    rst_ni = 0;
    #1;
    chk("midrst_rsp_valid", rsp_valid_o, 2'b00);
    chk("midrst_unit_valid", unit_valid_o, 0);
    q.delete();
    for (int r = 0; r < N; r++) begin
      exp_res[r].delete();
      starve_cnt[r] = 0;
    end
    rr = 0;
    @(posedge clk); #1;
    rst_ni = 1;
    step();
    chk("post_rst_grant_r0", req_ready_o, 2'b01);
    tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
